// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter; optional input FIFO via PS2_TX_FIFO_EN
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int RTS_TIMEOUT_CYCLES = 750000,
  parameter int XFER_TIMEOUT_CYCLES = 100000,
  parameter int FIFO_AW = 2
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_error
);
  localparam int TMAX = RTS_TIMEOUT_CYCLES > XFER_TIMEOUT_CYCLES ? RTS_TIMEOUT_CYCLES : XFER_TIMEOUT_CYCLES;
  localparam int CMAX = TMAX > INHIBIT_CYCLES ? TMAX : INHIBIT_CYCLES;
  localparam int CW = $clog2(CMAX + 1);
  typedef enum logic [2:0] {IDLE, INHIBIT, RTS, DATA, ACK, WAIT_IDLE, ERR} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [9:0] sh;
  logic [3:0] bitn;
  logic nack;
  logic [1:0] clk_s, dat_s;
  logic clk_prev, fall;
  logic start;
  logic [7:0] start_data;
`ifdef PS2_TX_FIFO_EN
  logic [7:0] mem [2**FIFO_AW];
  logic [FIFO_AW:0] wp, rp;
  logic empty, full, push;
  assign empty = wp == rp;
  assign full = (wp ^ rp) == {1'b1, {FIFO_AW{1'b0}}};
  assign push = tx_valid & ~full;
  assign start = (state == IDLE) & ~empty;
  assign start_data = mem[rp[FIFO_AW-1:0]];
  assign tx_ready = ~full;
  assign busy = (state != IDLE) | ~empty;
  // FIFO storage: written on every accepted byte, no reset needed
  always_ff @(posedge CLOCK_50)
    if (push) mem[wp[FIFO_AW-1:0]] <= tx_data;
  // FIFO pointers: push on accept, pop when the FSM picks up a byte
  always_ff @(posedge CLOCK_50 or posedge reset)
    if (reset) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (start) rp <= rp + 1'b1;
    end
`else
  assign start = (state == IDLE) & tx_valid;
  assign start_data = tx_data;
  assign tx_ready = state == IDLE;
  assign busy = state != IDLE;
`endif
  // Pad synchronisers and registered falling-edge detect of the device clock; bus idles high
  always_ff @(posedge CLOCK_50 or posedge reset)
    if (reset) begin
      clk_s <= 2'b11;
      dat_s <= 2'b11;
      clk_prev <= 1'b1;
      fall <= 1'b0;
    end else begin
      clk_s <= {clk_s[0], ps2_clk_in};
      dat_s <= {dat_s[0], ps2_dat_in};
      clk_prev <= clk_s[1];
      fall <= clk_prev & ~clk_s[1];
    end
  // Transmit FSM: inhibit, request-to-send, shift frame on device falls, check ACK
  always_ff @(posedge CLOCK_50 or posedge reset)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      sh <= '0;
      bitn <= '0;
      nack <= 1'b0;
      ps2_clk_oe <= 1'b0;
      ps2_dat_oe <= 1'b0;
      tx_done <= 1'b0;
      tx_error <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      tx_error <= 1'b0;
      case (state)
        IDLE: if (start) begin
          sh <= {1'b1, ~^start_data, start_data};
          cnt <= '0;
          ps2_clk_oe <= 1'b1;
          state <= INHIBIT;
        end
        INHIBIT: begin
          cnt <= cnt + 1'b1;
          if (cnt == CW'(INHIBIT_CYCLES - 2)) ps2_dat_oe <= 1'b1;
          if (cnt == CW'(INHIBIT_CYCLES - 1)) begin
            ps2_clk_oe <= 1'b0;
            cnt <= '0;
            state <= RTS;
          end
        end
        RTS: if (fall) begin
          ps2_dat_oe <= ~sh[0];
          sh <= {1'b1, sh[9:1]};
          bitn <= '0;
          cnt <= '0;
          state <= DATA;
        end else if (cnt == CW'(RTS_TIMEOUT_CYCLES)) begin
          ps2_dat_oe <= 1'b0;
          state <= ERR;
        end else cnt <= cnt + 1'b1;
        DATA, ACK, WAIT_IDLE: begin
          cnt <= cnt + 1'b1;
          if (cnt == CW'(XFER_TIMEOUT_CYCLES)) begin
            ps2_dat_oe <= 1'b0;
            state <= ERR;
          end else if (state == DATA) begin
            if (fall) begin
              ps2_dat_oe <= ~sh[0];
              sh <= {1'b1, sh[9:1]};
              bitn <= bitn + 1'b1;
              if (bitn == 4'd8) state <= ACK;
            end
          end else if (state == ACK) begin
            if (fall) begin
              nack <= dat_s[1];
              state <= WAIT_IDLE;
            end
          end else if (clk_s[1] & dat_s[1]) begin
            tx_done <= 1'b1;
            tx_error <= nack;
            state <= IDLE;
          end
        end
        ERR: begin
          ps2_clk_oe <= 1'b0;
          ps2_dat_oe <= 1'b0;
          tx_done <= 1'b1;
          tx_error <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed and randomized PS/2 host transmit checks against a device model
module tb_ps2_host_tx;
  localparam int INH = 40;
  localparam int RTS = 300;
  localparam int XFR = 1000;
  localparam int H = 15;
  logic CLOCK_50 = 1'b0;
  logic reset = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic tx_valid = 1'b0;
  logic tx_ready, ps2_clk_oe, ps2_dat_oe, busy, tx_done, tx_error;
  logic ps2_clk_in, ps2_dat_in;
  logic dev_clk_low = 1'b0;
  logic dev_dat_low = 1'b0;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  assign ps2_clk_in = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_dat_in = ~(ps2_dat_oe | dev_dat_low);
  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .RTS_TIMEOUT_CYCLES(RTS),
    .XFER_TIMEOUT_CYCLES(XFR),
    .FIFO_AW(2)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .reset(reset),
    .tx_data(tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .ps2_clk_in(ps2_clk_in),
    .ps2_dat_in(ps2_dat_in),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_dat_oe(ps2_dat_oe),
    .busy(busy),
    .tx_done(tx_done),
    .tx_error(tx_error)
  );
  always #10 CLOCK_50 = ~CLOCK_50;
  always @(posedge CLOCK_50) cyc <= cyc + 1;
  always @(negedge CLOCK_50) if (tx_done) done_cnt <= done_cnt + 1;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [7:0] d);
    int i = 0;
    while (!tx_ready && i < 200) begin
      @(negedge CLOCK_50);
      i++;
    end
    chk("ready_before_send", 32'(tx_ready), 32'd1);
    tx_data = d;
    tx_valid = 1'b1;
    @(negedge CLOCK_50);
    tx_valid = 1'b0;
  endtask
  // mode: 0 ACK, 1 NACK, 2 device silent, 3 device stalls mid-frame, 4 reset after 3rd data bit
  task automatic frame(input logic [7:0] d, input int mode, input logic exp_busy);
    int n, ov, np, t0, tdone, d0;
    logic [9:0] got, exp;
    logic par, seen, err, bsy, cl, dl, rdy;
    n = 0;
    ov = 0;
    got = '0;
    d0 = done_cnt;
    par = ($countones(d) % 2) == 0;
    exp = {1'b1, par, d};
    for (int i = 0; i < 50 && !ps2_clk_oe; i++) @(negedge CLOCK_50);
    t0 = cyc;
    while (ps2_clk_oe && n < 4 * INH) begin
      n++;
      if (ps2_dat_oe) ov++;
      @(negedge CLOCK_50);
    end
    chk("inhibit_len", 32'(n), 32'(INH));
    chk("rts_overlap", 32'(ov), 32'd1);
    chk("rts_dat_low", 32'(ps2_dat_oe), 32'd1);
    np = mode < 2 ? 11 : mode == 3 ? 5 : mode == 4 ? 3 : 0;
    repeat (10) @(negedge CLOCK_50);
    for (int k = 0; k < np; k++) begin
      if (k == 10 && mode == 0) begin
        dev_dat_low = 1'b1;
        repeat (5) @(negedge CLOCK_50);
      end
      dev_clk_low = 1'b1;
      repeat (H) @(negedge CLOCK_50);
      if (k < 10) got[k] = ps2_dat_in;
      dev_clk_low = 1'b0;
      if (k < np - 1) repeat (H) @(negedge CLOCK_50);
    end
    dev_dat_low = 1'b0;
    if (mode == 4) begin
      chk("abort_bits", 32'(got[2:0]), 32'(exp[2:0]));
      reset = 1'b1;
      #1;
      chk("abort_clk_oe", 32'(ps2_clk_oe), 32'd0);
      chk("abort_dat_oe", 32'(ps2_dat_oe), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      repeat (3) @(negedge CLOCK_50);
      reset = 1'b0;
      repeat (50) @(negedge CLOCK_50);
      chk("abort_no_done", 32'(done_cnt), 32'(d0));
      chk("abort_ready", 32'(tx_ready), 32'd1);
    end else begin
      seen = 1'b0;
      err = 1'b0;
      bsy = 1'b1;
      cl = 1'b1;
      dl = 1'b1;
      rdy = 1'b0;
      tdone = 0;
      for (int i = 0; i < RTS + XFR + 200 && !seen; i++) begin
        @(negedge CLOCK_50);
        if (tx_done) begin
          seen = 1'b1;
          err = tx_error;
          bsy = busy;
          cl = ps2_clk_oe;
          dl = ps2_dat_oe;
          rdy = tx_ready;
          tdone = cyc;
        end
      end
      chk("done_seen", 32'(seen), 32'd1);
      chk("done_error", 32'(err), 32'(mode != 0));
      chk("done_busy", 32'(bsy), 32'(exp_busy));
      chk("done_clk_rel", 32'(cl), 32'd0);
      chk("done_dat_rel", 32'(dl), 32'd0);
      if (!exp_busy) chk("done_ready", 32'(rdy), 32'd1);
      if (mode < 2) chk("frame_bits", 32'(got), 32'(exp));
      if (mode == 2) chk("rts_timeout_time", 32'((tdone - t0) >= INH + RTS - 2 && (tdone - t0) <= INH + RTS + 6), 32'd1);
      @(negedge CLOCK_50);
      chk("done_one_cycle", 32'(tx_done), 32'd0);
    end
  endtask
  task automatic xfer(input logic [7:0] d, input int mode);
    send(d);
    frame(d, mode, 1'b0);
  endtask
  initial begin
    logic [7:0] b [5];
    logic [4:0] rdy;
    int m;
    repeat (3) @(negedge CLOCK_50);
    chk("rst_ready", 32'(tx_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_oe", 32'({ps2_clk_oe, ps2_dat_oe}), 32'd0);
    chk("rst_done", 32'({tx_done, tx_error}), 32'd0);
    reset = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    chk("idle_ready", 32'(tx_ready), 32'd1);
    xfer(8'hED, 0);
    xfer(8'h01, 0);
    xfer(8'h00, 0);
    xfer(8'($urandom_range(0, 255)), 1);
    xfer(8'($urandom_range(0, 255)), 2);
    xfer(8'($urandom_range(0, 255)), 3);
    xfer(8'($urandom_range(0, 255)), 4);
    xfer(8'hFF, 0);
    for (int i = 0; i < 4; i++) begin
      m = int'($urandom_range(0, 1));
      xfer(8'($urandom_range(0, 255)), m);
    end
`ifdef PS2_TX_FIFO_EN
    for (int i = 0; i < 5; i++) b[i] = 8'($urandom_range(0, 255));
    send(b[0]);
    fork
      begin
        for (int i = 0; i < 5; i++) begin
          tx_data = b[i == 4 ? 4 : i + 1];
          tx_valid = 1'b1;
          rdy[i] = tx_ready;
          @(negedge CLOCK_50);
        end
        tx_valid = 1'b0;
      end
      frame(b[0], 0, 1'b1);
    join
    chk("fifo_ready_pattern", 32'(rdy), 32'b01111);
    for (int i = 1; i < 5; i++) frame(b[i], 0, i < 4);
    repeat (20) @(negedge CLOCK_50);
    chk("fifo_drained_busy", 32'(busy), 32'd0);
`else
    b[0] = 8'h3C;
    send(b[0]);
    fork
      frame(b[0], 0, 1'b0);
      begin
        repeat (60) @(negedge CLOCK_50);
        tx_data = 8'h55;
        tx_valid = 1'b1;
        rdy = 5'd0;
        for (int i = 0; i < 20; i++) begin
          if (tx_ready) rdy[0] = 1'b1;
          @(negedge CLOCK_50);
        end
        tx_valid = 1'b0;
      end
    join
    chk("busy_valid_not_ready", 32'(rdy[0]), 32'd0);
    m = done_cnt;
    repeat (30) @(negedge CLOCK_50);
    chk("busy_valid_ignored", 32'({busy, ps2_clk_oe}), 32'd0);
    chk("busy_valid_no_done", 32'(done_cnt), 32'(m));
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
